fxp_seq_alu: RTL and testbench
==============================

// Module: fxp_seq_alu
// PURPOSE
//  Parametrised, handshaked successor of the fixed-point processing unit. Signed Qm.f
//  arithmetic: add/sub/mul/div, sign ops, compare, min/max.
//  Adds configurable saturation, multiply rounding, status flags and valid/ready flow.
//  Division is a registered one-bit-per-cycle iterative divider.
//  Sits between the core register read stage and writeback; the core stalls while op_ready=0.
// PARAMETERS
//  INT_BITS   16  integer bits incl. sign; 1.0 = 1<<FRAC_BITS
//  FRAC_BITS  48  fraction bits; WIDTH = INT_BITS+FRAC_BITS (default 64)
//  SATURATE   1   1: clamp out-of-range results to MAX/MIN; 0: two's-complement wrap
//  MUL_ROUND  1   1: add 1<<(FRAC_BITS-1) before product shift; 0: truncate (floor)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  op_valid     in   1      request present
//  op_ready     out  1      unit idle, request accepted when op_valid&&op_ready
//  fpu_op       in   4      opcode, encoding below
//  a_data       in   WIDTH  signed operand A
//  b_data       in   WIDTH  signed operand B
//  res_valid    out  1      fpu_res/flags valid
//  res_ready    in   1      consumer takes result
//  fpu_res      out  WIDTH  signed result
//  overflow     out  1      result clamped (SATURATE=1) or wrapped (SATURATE=0)
//  div_by_zero  out  1      DIV with B==0
//  illegal_op   out  1      unused opcode
//  busy         out  1      state!=IDLE
// BEHAVIOUR
//  Ops: 0000 A+B | 0001 A-B | 0010 A*B | 0011 A/B | 0100 sign(B)*|A| | 0101 -sign(B)*|A|
//   0110 (sign(A)^sign(B))*|A| | 1010 A==B | 1001 A<B | 1011 A<=B (ONE or 0)
//   1100 min | 1101 max. Others: res=0, illegal_op=1.
//  Reset (async): state=IDLE, fpu_res=0, res_valid=0, all flags=0, op_ready=1.
//   In-flight division is discarded; no result is produced for it.
//  FSM IDLE/DIV/HOLD; op_ready = (state==IDLE). Operands and opcode latched on accept.
//   IDLE, accept, op!=0011: compute, register result, -> HOLD (res_valid next cycle).
//   IDLE, accept, op==0011, B==0: res=A>=0?MAX:MIN, div_by_zero=1, overflow=0, -> HOLD.
//   IDLE, accept, op==0011, B!=0: -> DIV, N=WIDTH+FRAC_BITS restoring iterations.
//    Accept edge = cycle 0; iterations in cycles 1..N; res_valid high in cycle N+1.
//   HOLD: res_valid=1; fpu_res and flags stable until res_ready; then -> IDLE.
//   res_ready is ignored outside HOLD. No accept in the same cycle as retire (1 op / 2 cycles min).
//  Arithmetic (MAX=2^(WIDTH-1)-1, MIN=-2^(WIDTH-1)):
//   add/sub: WIDTH+1-bit exact sum; out of range -> overflow=1, clamp or wrap per SATURATE.
//   mul: 2*WIDTH-bit product, optional round, arithmetic >>> FRAC_BITS.
//    Range-checked like add/sub.
//   div: magnitudes |A|<<FRAC_BITS / |B|; quotient truncates toward zero.
//    Sign = sign(A)^sign(B). Magnitude > MAX (or > 2^(WIDTH-1) if negative) -> overflow.
//   sign ops: |MIN| is not representable; negating MIN gives MAX with overflow=1 (SATURATE=1).
//   compares/min/max: signed; never set overflow.
//  Flags are registered with fpu_res, valid only while res_valid=1, cleared on next accept.
// TESTING (default params; ONE=64'h0001_0000_0000_0000)
//  1. add 1.5 (0x0001_8000..) + 2.25 (0x0002_4000..); res_ready low 3 cycles
//     -> res 0x0003_C000_0000_0000 from cycle 1, held stable, then IDLE.
//  2. add 0x7FFF_FFFF_FFFF_FFFF + ONE -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1.
//     Same with SATURATE=0 -> 0x8000_FFFF_FFFF_FFFF, overflow=1.
//  3. mul -2.0 (0xFFFE_0000..) * 0.5 (0x0000_8000..) -> 0xFFFF_0000_0000_0000, no flags.
//  4. div ONE / 3.0 -> 0x0000_5555_5555_5555, res_valid at cycle 113, op_ready=0 cycles 1..113.
//     div -ONE / 3.0 -> 0xFFFF_AAAA_AAAA_AAAB.
//  5. div 5.0 / 0 -> 0x7FFF_FFFF_FFFF_FFFF, div_by_zero=1, res_valid at cycle 1.
//     opcode 4'b0111 -> res 0, illegal_op=1.
//  6. reset pulse at cycle 40 of a division -> res_valid/flags 0 immediately, op_ready=1 after release.
//     Following cmp 1.0<=1.0 returns ONE at cycle 1.

Source files
------------

// File: rtl/fxp_seq_alu.sv
// rtl/fxp_seq_alu.sv - handshaked signed Qm.f fixed-point ALU with iterative divider
//
// Purpose: signed fixed-point add/sub/mul/div, sign transfer ops, compares and
// min/max. Results can saturate or wrap, multiply products can be rounded, and
// status flags are returned with each result. Division is computed by a restoring
// divider that produces one quotient bit per cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   op_valid     request present
//   op_ready     unit idle; request accepted when op_valid && op_ready
//   fpu_op       4-bit opcode
//   a_data       signed operand A
//   b_data       signed operand B
//   res_valid    fpu_res and flags valid
//   res_ready    consumer takes the result
//   fpu_res      signed result
//   overflow     result clamped (SATURATE=1) or wrapped (SATURATE=0)
//   div_by_zero  DIV with B == 0
//   illegal_op   unused opcode
//   busy         unit not idle
module fxp_seq_alu #(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 48,
  parameter int SATURATE  = 1,
  parameter int MUL_ROUND = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [3:0]                    fpu_op,
  input  logic [INT_BITS+FRAC_BITS-1:0] a_data,
  input  logic [INT_BITS+FRAC_BITS-1:0] b_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] fpu_res,
  output logic                          overflow,
  output logic                          div_by_zero,
  output logic                          illegal_op,
  output logic                          busy
);
  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int QW = W + FRAC_BITS;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE = {{(INT_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [2*W-1:0] MAX_X = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MIN_X = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] RND = (MUL_ROUND != 0) ?
      {{(2*W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}} : '0;
  // Largest quotient magnitudes that still fit for positive / negative results.
  localparam logic [QW-1:0] Q_MAX = {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN = {{(QW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011, OP_CPS = 4'b0100, OP_CPN = 4'b0101;
  localparam logic [3:0] OP_XS  = 4'b0110, OP_LT  = 4'b1001, OP_EQ  = 4'b1010;
  localparam logic [3:0] OP_LE  = 4'b1011, OP_MIN = 4'b1100, OP_MAX = 4'b1101;

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;
  state_t state, state_nxt;

  // Range-check a wide signed value: {overflow, result}.
  function automatic logic [W:0] fit(input logic signed [2*W-1:0] v);
    if (v > MAX_X) return {1'b1, (SATURATE != 0) ? MAX : v[W-1:0]};
    if (v < MIN_X) return {1'b1, (SATURATE != 0) ? MIN : v[W-1:0]};
    return {1'b0, v[W-1:0]};
  endfunction

  logic signed [W-1:0]   a_s, b_s;
  logic signed [W:0]     a_x, b_x, a_abs_x, sum_add, sum_sub, sgn_v;
  logic signed [2*W-1:0] prod_r, prod_q;
  logic                  neg_out, use_fit, ovf_c, dbz_c, ill_c;
  logic [W:0]            fit_r;
  logic [W-1:0]          res_c, a_mag, b_mag;

  assign a_s     = a_data;
  assign b_s     = b_data;
  assign a_x     = {a_data[W-1], a_data};
  assign b_x     = {b_data[W-1], b_data};
  assign sum_add = a_x + b_x;
  assign sum_sub = a_x - b_x;
  assign a_abs_x = a_data[W-1] ? -a_x : a_x;
  assign prod_r  = a_s * b_s + RND;
  assign prod_q  = prod_r >>> FRAC_BITS;
  assign neg_out = (fpu_op == OP_CPS) ? b_data[W-1] :
                   (fpu_op == OP_CPN) ? ~b_data[W-1] : (a_data[W-1] ^ b_data[W-1]);
  // |MIN| needs W+1 bits, so the sign ops go through the same range check.
  assign sgn_v   = neg_out ? -a_abs_x : a_abs_x;
  assign a_mag   = a_data[W-1] ? -a_data : a_data;
  assign b_mag   = b_data[W-1] ? -b_data : b_data;

  always_comb begin
    res_c   = '0;
    ovf_c   = 1'b0;
    dbz_c   = 1'b0;
    ill_c   = 1'b0;
    use_fit = 1'b0;
    fit_r   = '0;
    case (fpu_op)
      OP_ADD: begin use_fit = 1'b1; fit_r = fit({{(W-1){sum_add[W]}}, sum_add}); end
      OP_SUB: begin use_fit = 1'b1; fit_r = fit({{(W-1){sum_sub[W]}}, sum_sub}); end
      OP_MUL: begin use_fit = 1'b1; fit_r = fit(prod_q); end
      OP_DIV: if (b_data == '0) begin
        res_c = a_data[W-1] ? MIN : MAX;
        dbz_c = 1'b1;
      end
      OP_CPS, OP_CPN, OP_XS: begin
        use_fit = 1'b1;
        fit_r   = fit({{(W-1){sgn_v[W]}}, sgn_v});
      end
      OP_LT:  res_c = (a_s <  b_s) ? ONE : '0;
      OP_EQ:  res_c = (a_s == b_s) ? ONE : '0;
      OP_LE:  res_c = (a_s <= b_s) ? ONE : '0;
      OP_MIN: res_c = (a_s <  b_s) ? a_data : b_data;
      OP_MAX: res_c = (a_s <  b_s) ? b_data : a_data;
      default: ill_c = 1'b1;
    endcase
    if (use_fit) begin
      res_c = fit_r[W-1:0];
      ovf_c = fit_r[W];
    end
  end

  // Restoring divider: qd shifts the dividend out of its MSB while quotient
  // bits enter at the LSB, so after QW steps qd holds the quotient.
  logic [W-1:0]  rem, dvs, rem_nxt, div_mag, div_res;
  logic [W:0]    rem_sh;
  logic [QW-1:0] qd, qd_nxt;
  logic [CW-1:0] cnt;
  logic          neg_q, ge, div_ovf;

  assign rem_sh  = {rem, qd[QW-1]};
  assign ge      = rem_sh >= {1'b0, dvs};
  assign rem_nxt = ge ? (rem_sh[W-1:0] - dvs) : rem_sh[W-1:0];
  assign qd_nxt  = {qd[QW-2:0], ge};

  // Final step result is formed from qd_nxt so the answer lands on the last iteration edge.
  always_comb begin
    div_ovf = neg_q ? (qd_nxt > Q_MIN) : (qd_nxt > Q_MAX);
    div_mag = neg_q ? -qd_nxt[W-1:0] : qd_nxt[W-1:0];
    div_res = div_mag;
    if (div_ovf && (SATURATE != 0)) div_res = neg_q ? MIN : MAX;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        busy     = 1'b0;
        if (op_valid) state_nxt = (fpu_op == OP_DIV && b_data != '0) ? DIV : HOLD;
      end
      DIV:  if (cnt == LAST) state_nxt = HOLD;
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpu_res     <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      rem         <= '0;
      dvs         <= '0;
      qd          <= '0;
      neg_q       <= 1'b0;
      cnt         <= '0;
    end else if (op_valid && op_ready) begin
      // A started division clears result and flags until it completes.
      fpu_res     <= res_c;
      overflow    <= ovf_c;
      div_by_zero <= dbz_c;
      illegal_op  <= ill_c;
      rem         <= '0;
      dvs         <= b_mag;
      qd          <= {a_mag, {FRAC_BITS{1'b0}}};
      neg_q       <= a_data[W-1] ^ b_data[W-1];
      cnt         <= '0;
    end else if (state == DIV) begin
      rem <= rem_nxt;
      qd  <= qd_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        fpu_res  <= div_res;
        overflow <= div_ovf;
      end
    end
  end
endmodule

// File: tb/tb_fxp_seq_alu.sv
// tb/tb_fxp_seq_alu.sv - scoreboard bench for fxp_seq_alu (saturating and wrapping builds)
module tb_fxp_seq_alu;
  localparam logic [63:0] ONE  = 64'h0001_0000_0000_0000;
  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0, reset = 1'b1, op_valid = 1'b0, res_ready = 1'b1;
  logic [3:0]  fpu_op = 4'b0;
  logic [63:0] a_data = '0, b_data = '0;
  logic        op_ready_s, res_valid_s, ovf_s, dbz_s, ill_s, busy_s;
  logic        op_ready_w, res_valid_w, ovf_w, dbz_w, ill_w, busy_w;
  logic [63:0] fpu_res_s, fpu_res_w;

  always #5 clk = ~clk;

  fxp_seq_alu #(.SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready_s),
    .fpu_op(fpu_op), .a_data(a_data), .b_data(b_data), .res_valid(res_valid_s),
    .res_ready(res_ready), .fpu_res(fpu_res_s), .overflow(ovf_s),
    .div_by_zero(dbz_s), .illegal_op(ill_s), .busy(busy_s));

  fxp_seq_alu #(.SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready_w),
    .fpu_op(fpu_op), .a_data(a_data), .b_data(b_data), .res_valid(res_valid_w),
    .res_ready(res_ready), .fpu_res(fpu_res_w), .overflow(ovf_w),
    .div_by_zero(dbz_w), .illegal_op(ill_w), .busy(busy_w));

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
    logic        dbz;
    logic        ill;
  } exp_t;

  exp_t q_s[$], q_w[$];
  exp_t e_s, e_w;
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed result handshake.
  always @(negedge clk) begin
    if (res_valid_s && res_ready) begin
      if (q_s.size() == 0) check("sat_unexpected_result", 64'(res_valid_s), 64'd0);
      else begin
        e_s = q_s.pop_front();
        check("sat_res", fpu_res_s, e_s.res);
        check("sat_flags", 64'({ovf_s, dbz_s, ill_s}), 64'({e_s.ovf, e_s.dbz, e_s.ill}));
      end
    end
    if (res_valid_w && res_ready) begin
      if (q_w.size() == 0) check("wrap_unexpected_result", 64'(res_valid_w), 64'd0);
      else begin
        e_w = q_w.pop_front();
        check("wrap_res", fpu_res_w, e_w.res);
        check("wrap_flags", 64'({ovf_w, dbz_w, ill_w}), 64'({e_w.ovf, e_w.dbz, e_w.ill}));
      end
    end
  end

  // Issue one op to both builds; rs/rw are the saturating/wrapping expected results.
  task automatic issue(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] rs, input logic [63:0] rw,
                       input logic ovf, input logic dbz, input logic ill, input int lat);
    int n = 0;
    bit rdy_low = 1'b1;
    while (!op_ready_s && n < 300) begin @(posedge clk); #1; n++; end
    check({name, "_accept_ready"}, 64'(op_ready_s), 64'd1);
    op_valid = 1'b1; fpu_op = op; a_data = a; b_data = b;
    q_s.push_back('{rs, ovf, dbz, ill});
    q_w.push_back('{rw, ovf, dbz, ill});
    @(posedge clk); #1;
    op_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (op_ready_s) rdy_low = 1'b0;
    end while (!res_valid_s && n < 300);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_op_ready_low"}, 64'(rdy_low), 64'd1);
    if (res_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("reset_res_valid", 64'(res_valid_s), 64'd0);
    check("reset_op_ready", 64'(op_ready_s), 64'd1);
    check("reset_busy", 64'(busy_s), 64'd0);
    check("reset_res", fpu_res_s, 64'd0);
    check("reset_flags", 64'({ovf_s, dbz_s, ill_s}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Add with the consumer stalling: result must hold until res_ready.
    res_ready = 1'b0;
    issue("add", 4'b0000, 64'h0001_8000_0000_0000, 64'h0002_4000_0000_0000,
          64'h0003_C000_0000_0000, 64'h0003_C000_0000_0000, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_res", fpu_res_s, 64'h0003_C000_0000_0000);
      check("hold_valid", 64'(res_valid_s), 64'd1);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("retire_idle", 64'({op_ready_s, busy_s, res_valid_s}), 64'b100);

    issue("add_ovf", 4'b0000, MAXV, ONE, MAXV, 64'h8000_FFFF_FFFF_FFFF, 1, 0, 0, 1);
    issue("sub_ovf", 4'b0001, MINV, ONE, MINV, 64'h7FFF_0000_0000_0000, 1, 0, 0, 1);
    issue("mul", 4'b0010, 64'hFFFE_0000_0000_0000, 64'h0000_8000_0000_0000,
          64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 0, 0, 0, 1);
    issue("mul_round", 4'b0010, 64'h1, 64'h0000_8000_0000_0000, 64'h1, 64'h1, 0, 0, 0, 1);
    issue("mul_ovf", 4'b0010, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000,
          MAXV, 64'h0, 1, 0, 0, 1);
    issue("div", 4'b0011, ONE, 64'h0003_0000_0000_0000,
          64'h0000_5555_5555_5555, 64'h0000_5555_5555_5555, 0, 0, 0, 113);
    issue("div_neg", 4'b0011, 64'hFFFF_0000_0000_0000, 64'h0003_0000_0000_0000,
          64'hFFFF_AAAA_AAAA_AAAB, 64'hFFFF_AAAA_AAAA_AAAB, 0, 0, 0, 113);
    issue("div_ovf", 4'b0011, 64'h4000_0000_0000_0000, 64'h0000_8000_0000_0000,
          MAXV, MINV, 1, 0, 0, 113);
    issue("div0", 4'b0011, 64'h0005_0000_0000_0000, 64'h0, MAXV, MAXV, 0, 1, 0, 1);
    issue("div0_neg", 4'b0011, 64'hFFFB_0000_0000_0000, 64'h0, MINV, MINV, 0, 1, 0, 1);
    issue("illegal", 4'b0111, ONE, ONE, 64'h0, 64'h0, 0, 0, 1, 1);
    issue("cps_min", 4'b0100, MINV, ONE, MAXV, MINV, 1, 0, 0, 1);
    issue("cpn", 4'b0101, 64'h0002_0000_0000_0000, ONE,
          64'hFFFE_0000_0000_0000, 64'hFFFE_0000_0000_0000, 0, 0, 0, 1);
    issue("xs", 4'b0110, 64'hFFFE_8000_0000_0000, 64'hFFFF_0000_0000_0000,
          64'h0001_8000_0000_0000, 64'h0001_8000_0000_0000, 0, 0, 0, 1);
    issue("lt", 4'b1001, 64'hFFFF_0000_0000_0000, ONE, ONE, ONE, 0, 0, 0, 1);
    issue("eq", 4'b1010, 64'h0002_0000_0000_0000, 64'h0003_0000_0000_0000,
          64'h0, 64'h0, 0, 0, 0, 1);
    issue("min", 4'b1100, 64'hFFFF_0000_0000_0000, 64'h0002_0000_0000_0000,
          64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 0, 0, 0, 1);
    issue("max", 4'b1101, 64'hFFFF_0000_0000_0000, 64'h0002_0000_0000_0000,
          64'h0002_0000_0000_0000, 64'h0002_0000_0000_0000, 0, 0, 0, 1);

    // Division aborted by reset: no result may appear afterwards.
    op_valid = 1'b1; fpu_op = 4'b0011; a_data = ONE; b_data = 64'h0003_0000_0000_0000;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (39) @(posedge clk);
    #2;
    check("abort_busy_before_reset", 64'(busy_s), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_res_valid", 64'({res_valid_s, res_valid_w}), 64'd0);
    check("abort_flags", 64'({ovf_s, dbz_s, ill_s}), 64'd0);
    check("abort_res", fpu_res_s, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_op_ready", 64'(op_ready_s), 64'd1);
    repeat (120) @(posedge clk);
    #1;
    issue("cmp_le", 4'b1011, ONE, ONE, ONE, ONE, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    check("sat_queue_empty", 64'(q_s.size()), 64'd0);
    check("wrap_queue_empty", 64'(q_w.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
